// File: rtl/dmem_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : dmem_arbiter_if                                           |
// | Purpose  : Bundle of pipeline MEM-stage, DMA/debug and data-memory   |
// |            signals seen by dmem_arbiter.                             |
// | Modports : slave  - the arbiter itself                               |
// |            master - the surrounding pipeline / DMA / memory          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int WORD_LEN = 32
);
  // Pipeline MEM stage
  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic [WORD_LEN-1:0] ALU_res;
  logic [WORD_LEN-1:0] ST_value;
  logic                pipe_stall;
  logic [WORD_LEN-1:0] dataMem_out;
  // DMA / debug port
  logic                dma_req;
  logic                dma_we;
  logic [WORD_LEN-1:0] dma_addr;
  logic [WORD_LEN-1:0] dma_wdata;
  logic                dma_ack;
  logic [WORD_LEN-1:0] dma_rdata;
  // Data memory
  logic                mem_read_en;
  logic                mem_write_en;
  logic [WORD_LEN-1:0] mem_address;
  logic [WORD_LEN-1:0] mem_data_in;
  logic [WORD_LEN-1:0] mem_data_out;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_res, ST_value,
    output pipe_stall, dataMem_out,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_read_en, mem_write_en, mem_address, mem_data_in,
    input  mem_data_out
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_res, ST_value,
    input  pipe_stall, dataMem_out,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_read_en, mem_write_en, mem_address, mem_data_in,
    output mem_data_out
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : dmem_arbiter                                              |
// | Purpose  : Shares one fixed-latency data memory between the MEM      |
// |            pipeline stage and a DMA/debug port. Each access lasts    |
// |            WAIT_CYCLES cycles; the pipeline is stalled until its own |
// |            access completes.                                         |
// | Options  : DMEM_ARB_RR_EN - round-robin on a tie (default: pipeline  |
// |            always wins a tie).                                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int WAIT_CYCLES = 2,   // 1..255
  parameter int WORD_LEN    = 32
) (
  input wire             clk,
  input wire             rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    GR_PIPE = 1'b0,
    GR_DMA  = 1'b1
  } grant_t;

  localparam logic [7:0] c_wait_load = 8'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_state_nxt;
  grant_t              r_grant;
  logic [7:0]          r_count;
  logic                r_we;
  logic [WORD_LEN-1:0] r_addr;
  logic [WORD_LEN-1:0] r_wdata;
  logic [WORD_LEN-1:0] r_pipe_rdata;
  logic [WORD_LEN-1:0] r_dma_rdata;

  logic w_pipe_req;
  logic w_dma_req;
  logic w_take_dma;
  logic w_grant_en;
  logic w_capture;
  logic w_busy;
  logic w_resp;

  assign w_pipe_req = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_dma_req  = bus.dma_req;

`ifdef DMEM_ARB_RR_EN
  grant_t r_last_grant;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_take_dma = w_dma_req;
    if (w_pipe_req && w_dma_req) begin
      w_take_dma = (r_last_grant == GR_PIPE);
    end
  end

  // Remember the most recent winner; reset value makes the first tie go to the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GR_DMA;
    end else if (w_grant_en) begin
      r_last_grant <= w_take_dma ? GR_DMA : GR_PIPE;
    end
  end
`else
  // Fixed priority: DMA is only served when the pipeline is quiet.
  assign w_take_dma = w_dma_req & ~w_pipe_req;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and all combinational outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_en       = 1'b0;
    w_capture        = 1'b0;
    w_busy           = 1'b0;
    w_resp           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pipe_req || w_dma_req) begin
          w_grant_en  = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_busy = 1'b1;
        if (r_count == 8'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Memory side is only active during BUSY, and quiet (zero) otherwise.
    bus.mem_read_en  = w_busy & ~r_we;
    bus.mem_write_en = w_busy & r_we;
    bus.mem_address  = w_busy ? r_addr : '0;
    bus.mem_data_in  = w_busy ? r_wdata : '0;
    // The pipeline is released only in the completion cycle of its own access.
    bus.pipe_stall   = w_pipe_req & ~(w_resp & (r_grant == GR_PIPE));
    bus.dma_ack      = w_resp & (r_grant == GR_DMA);
    bus.dataMem_out  = r_pipe_rdata;
    bus.dma_rdata    = r_dma_rdata;
  end

  // Latch the granted request and run the wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= GR_PIPE;
      r_count <= 8'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_en) begin
      r_grant <= w_take_dma ? GR_DMA : GR_PIPE;
      r_count <= c_wait_load;
      // A pipeline request with both enables high is treated as a store.
      r_we    <= w_take_dma ? bus.dma_we    : bus.MEM_W_EN;
      r_addr  <= w_take_dma ? bus.dma_addr  : bus.ALU_res;
      r_wdata <= w_take_dma ? bus.dma_wdata : bus.ST_value;
    end else if (r_state == ST_BUSY) begin
      r_count <= r_count - 8'd1;
    end
  end

  // Capture read data for the owner of the access on its last BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_rdata <= '0;
      r_dma_rdata  <= '0;
    end else if (w_capture && !r_we) begin
      if (r_grant == GR_DMA) begin
        r_dma_rdata <= bus.mem_data_out;
      end else begin
        r_pipe_rdata <= bus.mem_data_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and two-port arbiter for the data memory behind the MEM pipeline stage. It shares one fixed-latency data memory between the pipeline's MEM stage and a DMA/debug port. It stretches each access over a programmable number of wait cycles and freezes the pipeline via a stall output until the pipeline's access completes. It sits between the MEM stage request signals and the `dataMem` instance.

## Interface
- `WAIT_CYCLES`, default 2: memory access duration in cycles; legal range 1..255.
- `WORD_LEN`, default from `defines.v` (32): data/address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `MEM_R_EN` in 1: pipeline load request (level).
- `MEM_W_EN` in 1: pipeline store request (level).
- `ALU_res` in `WORD_LEN`: pipeline address.
- `ST_value` in `WORD_LEN`: pipeline store data.
- `pipe_stall` out 1: freeze upstream stages and hold the MEM stage.
- `dataMem_out` out `WORD_LEN`: pipeline load data (registered).
- `dma_req` in 1: DMA request (level, held until ack).
- `dma_we` in 1: DMA write=1 / read=0.
- `dma_addr` in `WORD_LEN`: DMA address.
- `dma_wdata` in `WORD_LEN`: DMA write data.
- `dma_ack` out 1: one-cycle completion pulse.
- `dma_rdata` out `WORD_LEN`: DMA read data (registered).
- `mem_read_en` out 1: to `dataMem.readEn`.
- `mem_write_en` out 1: to `dataMem.writeEn`.
- `mem_address` out `WORD_LEN`: to `dataMem.address`.
- `mem_data_in` out `WORD_LEN`: to `dataMem.dataIn`.
- `mem_data_out` in `WORD_LEN`: from `dataMem.dataOut`.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - A pipeline request exists when `MEM_R_EN|MEM_W_EN`. A DMA request exists when `dma_req`.
  - If any request exists, grant one requester, latch its address, write data and direction into internal registers, load the wait counter with `WAIT_CYCLES`, and go to BUSY.
  - If `MEM_R_EN` and `MEM_W_EN` are both high, the access is a write.
- BUSY:
  - Memory outputs are driven from the latched registers. `mem_write_en` or `mem_read_en` stays high throughout BUSY.
  - The counter decrements each cycle. On the cycle the counter equals 1, `mem_data_out` is captured into the granted requester's read-data register (reads only), and the FSM moves to RESP.
- RESP: the access is complete; return to IDLE next cycle. No new grant is made in RESP.
- `pipe_stall` is combinational: `(MEM_R_EN|MEM_W_EN) && !(state==RESP && grant==PIPE)`.
- `dma_ack` is high exactly in RESP with grant==DMA.
- Dropping `dma_req` mid-access does not abort the access; `dma_ack` still pulses.
- Read-data registers hold their value until the next completed read by the same requester. Writes do not alter them.
- Arbitration on a tie is governed by the Configuration section.
- Reset values: `pipe_stall` follows its inputs (combinational). All other outputs are 0: `dma_ack`, `dataMem_out`, `dma_rdata`, all `mem_*` outputs. The FSM is IDLE, the counter is 0, and `last_grant` is DMA.

## Timing
- Single access, idle start: IDLE (grant) → BUSY × `WAIT_CYCLES` → RESP. The completion cycle falls `WAIT_CYCLES+1` cycles after the request is seen.
- Back-to-back throughput: one access per `WAIT_CYCLES+2` cycles.
- Pipeline load: `dataMem_out` is valid in the RESP cycle, when `pipe_stall` is low and the pipeline advances at the clock edge.
- Memory enables are never asserted in IDLE or RESP. Address and data are stable for the whole of BUSY.
- Reset mid-access (`rst` high in BUSY or RESP): the next state is IDLE with all outputs at reset values. No `dma_ack` is issued. A write in flight may already have committed.
- A request arriving in RESP waits for IDLE; it is not lost because requests are level.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin on a tie. The requester not in `last_grant` wins, and `last_grant` updates on every grant. Because `last_grant` resets to DMA, the first tie goes to the pipeline.
- `DMEM_ARB_RR_EN` undefined: fixed priority, pipeline always wins a tie. `last_grant` logic is removed. DMA can starve while the pipeline streams memory ops.

## Test plan
- Pipeline load, `WAIT_CYCLES`=2, addr 0x10 holding 0xDEADBEEF: `pipe_stall` high for 3 cycles, low in RESP, `dataMem_out`=0xDEADBEEF. `mem_read_en` high exactly 2 cycles.
- DMA write 0x20←0x12345678, then pipeline load of 0x20: `dma_ack` is a single pulse, the load returns 0x12345678, and `dma_rdata` is unchanged.
- Simultaneous pipeline + DMA requests from reset, with the macro defined: pipeline is granted first, DMA second, and `dma_ack` lands at cycle 2×(`WAIT_CYCLES`+2). With the macro undefined and the pipeline requesting continuously, `dma_ack` is never asserted.
- Both `MEM_R_EN` and `MEM_W_EN` high, `ST_value`=0xA5A5A5A5: a write is performed, `mem_read_en` stays 0, and `dataMem_out` holds its previous value.
- `rst` pulsed on the second BUSY cycle of a DMA read: the next cycle is IDLE, all outputs are 0, and no `dma_ack` is issued. With `dma_req` still high, the access restarts cleanly.
- `WAIT_CYCLES`=1 boundary: each access takes 3 cycles and the enables are high for 1 cycle.
